uart_tx_arbiter: RTL

- Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
- Accepts a byte plus per-frame parity settings from the winning requester and drives the transmitter's parallel-load interface.
- Holds the frame data stable for the whole frame, because the transmitter's parity bit is computed from its live data input.
- Tracks frame completion through the transmitter's busy flag; sits between the host-side producers and the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Function : Round-robin scheduler sharing one UART transmitter among
//            NUM_REQ requesters. It latches the winner's byte and parity
//            settings and holds them for the whole frame. Frame completion
//            is tracked through the transmitter's busy flag.
// Options  : UART_ARB_TIMEOUT_EN - watchdog that aborts a grant when the
//            transmitter never raises busy within TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    input  logic [NUM_REQ-1:0]            req_par_typ,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          active,
    output logic                          timeout_err,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
    output logic                          tx_par_en,
    output logic                          tx_par_typ,
    input  logic                          tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ID_WIDTH-1:0] c_LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_found;
    logic                  w_settle;
    logic [ID_WIDTH-1:0]   w_idx;

    // Reject parameter sets the arbiter cannot represent
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_WIDTH) < NUM_REQ ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    // Unpack the per-requester byte lanes
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lanes
        assign w_req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = r_last_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_idx == c_LAST_ID) begin
                w_idx = '0;
            end else begin
                w_idx = w_idx + ID_WIDTH'(1);
            end
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt;

    // The cycle after a done or abort pulse is spent settling, not granting
    assign w_settle = (|done) || timeout_err;
`else
    assign w_settle    = |done;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM; all outputs are registered here
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last_grant  <= c_LAST_ID;
            ack           <= '0;
            done          <= '0;
            grant_id      <= '0;
            active        <= 1'b0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err   <= 1'b0;
            r_cnt         <= '0;
`endif
        end else begin
            ack  <= '0;
            done <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            r_cnt       <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found && !tx_busy && !w_settle) begin
                        tx_p_data     <= w_req_bytes[w_winner];
                        tx_par_en     <= req_par_en[w_winner];
                        tx_par_typ    <= req_par_typ[w_winner];
                        grant_id      <= w_winner;
                        ack           <= NUM_REQ'(1) << w_winner;
                        tx_data_valid <= 1'b1;
                        active        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_data_valid <= 1'b0;
                    r_state       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Transmitter never started: abort but still rotate
                        timeout_err  <= 1'b1;
                        active       <= 1'b0;
                        r_last_grant <= grant_id;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        done         <= NUM_REQ'(1) << grant_id;
                        r_last_grant <= grant_id;
                        active       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
